// File: rtl/zeroriscy_bnn_array.sv
// zeroriscy_bnn_array: N_CORES xnor-popcount BNN cores for the zero-riscy EX stage.
// Four-stage pipe: accept/weight request (A), weight capture (A+1), acc/pool update
// (A+2), ACTIV/IP8 result valid (A+3). Optional feature macro: BNN_IP8_EN enables
// op 5 as a 3x8-bit signed dot product; without it op 5 returns 32'h0.
module zeroriscy_bnn_array #(
  parameter int N_CORES = 32,
  parameter int ACC_W   = 16,
  parameter int PADDR_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   bnn_en_i,
  input  logic [2:0]             bnn_operator_i,
  input  logic [6:0]             bnn_param_i,
  input  logic [31:0]            bnn_addr_i,
  input  logic [31:0]            bnn_data_i,
  output logic                   bnn_ready_o,
  output logic                   bnn_valid_o,
  output logic [31:0]            bnn_result_o,
  output logic                   param_req_o,
  output logic [PADDR_W-1:0]     param_addr_o,
  input  logic [N_CORES*32-1:0]  param_rdata_i
);

  localparam logic [2:0] OP_INI   = 3'd0;
  localparam logic [2:0] OP_ACC   = 3'd1;
  localparam logic [2:0] OP_POOL  = 3'd2;
  localparam logic [2:0] OP_NORM  = 3'd3;
  localparam logic [2:0] OP_ACTIV = 3'd4;
  localparam logic [2:0] OP_IP8   = 3'd5;
  localparam logic [2:0] OP_SETEN = 3'd6;
  localparam logic [2:0] OP_NORM8 = 3'd7;

  localparam int N_GROUPS = (N_CORES / 32 > 1) ? N_CORES / 32 : 1;
  localparam int SIGN_W   = 32 * N_GROUPS;
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};

  logic                    accept;
  logic                    busy_q, busy_d;
  logic                    s1_vld_q, s2_vld_q;
  logic [2:0]              s1_op_q, s2_op_q;
  logic [31:0]             s1_addr_q, s2_addr_q;
  logic [31:0]             s1_data_q, s2_data_q;
  logic [N_CORES*32-1:0]   s2_w_q;
  logic                    valid_q, res_load;
  logic [31:0]             result_q, result_d, ip8_word;
  logic [SIGN_W-1:0]       sign_pad;
  int unsigned             act_sel;
  logic [31:0]             w_word;
  logic [5:0]              pop;
  logic [ACC_W:0]          acc_sum;
  logic signed [ACC_W-1:0] acc_q  [N_CORES];
  logic signed [ACC_W-1:0] pool_q [N_CORES];
  logic signed [ACC_W-1:0] acc_d  [N_CORES];
  logic signed [ACC_W-1:0] pool_d [N_CORES];

  assign bnn_ready_o  = ~busy_q;
  assign accept       = bnn_en_i & ~busy_q;
  assign param_req_o  = accept;
  assign bnn_valid_o  = valid_q;
  assign bnn_result_o = result_q;
  assign res_load     = s2_vld_q & ((s2_op_q == OP_ACTIV) | (s2_op_q == OP_IP8));

  // Weight-RAM address: plain address, or core-pair group plus offset for IP8.
  always_comb begin
    param_addr_o = bnn_addr_i[PADDR_W-1:0];
    if (bnn_operator_i == OP_IP8)
      param_addr_o = PADDR_W'(bnn_addr_i[7:4]) + PADDR_W'(bnn_param_i[4:0]);
  end

  // Busy spans from the cycle after a result op is accepted through its valid cycle.
  always_comb begin
    busy_d = busy_q;
    if (accept && (bnn_operator_i == OP_ACTIV || bnn_operator_i == OP_IP8)) busy_d = 1'b1;
    else if (valid_q)                                                        busy_d = 1'b0;
  end

  // Pipe valid bits, busy flag and the held result register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      s1_vld_q <= accept;
      s2_vld_q <= s1_vld_q;
      busy_q   <= busy_d;
      valid_q  <= res_load;
      if (res_load) result_q <= result_d;
    end
  end

`ifdef BNN_IP8_EN
  logic [1:0] s1_sft_q, s2_sft_q;
`else
  logic unused_sft;
  assign unused_sft = ^bnn_param_i[6:5];
`endif

  // Operand payload, qualified by the stage valid bits.
  // NOTE: payload flops carry no reset; the reset valid bits already make stale contents harmless.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op_q   <= bnn_operator_i;
      s1_addr_q <= bnn_addr_i;
      s1_data_q <= bnn_data_i;
`ifdef BNN_IP8_EN
      s1_sft_q  <= bnn_param_i[6:5];
`endif
    end
    if (s1_vld_q) begin
      s2_op_q   <= s1_op_q;
      s2_addr_q <= s1_addr_q;
      s2_data_q <= s1_data_q;
      s2_w_q    <= param_rdata_i;
`ifdef BNN_IP8_EN
      s2_sft_q  <= s1_sft_q;
`endif
    end
  end

  // Per-core next state for acc and pool.
  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    w_word  = '0;
    pop     = '0;
    acc_sum = '0;
    for (int g = 0; g < N_CORES; g++) begin
      acc_d[g]  = acc_q[g];
      pool_d[g] = pool_q[g];
      w_word    = s2_w_q[32*(N_CORES-1-g) +: 32];
      if (s2_vld_q) begin
        case (s2_op_q)
          OP_INI: begin
            acc_d[g]  = s2_data_q[ACC_W-1:0];
            pool_d[g] = ACC_MIN;
          end
          OP_ACC: begin
            pop     = 6'($countones(~(s2_data_q ^ w_word)));
            acc_sum = {acc_q[g][ACC_W-1], acc_q[g]} + {{(ACC_W-6){1'b0}}, pop, 1'b0};
            // Only a positive increment is added, so overflow can only go past +max.
            acc_d[g] = (acc_sum[ACC_W] ^ acc_sum[ACC_W-1]) ? ACC_MAX : acc_sum[ACC_W-1:0];
          end
          OP_POOL: begin
            if (acc_q[g] > pool_q[g]) pool_d[g] = acc_q[g];
            acc_d[g] = s2_data_q[ACC_W-1:0];
          end
          OP_NORM:  pool_d[g] = (pool_q[g] <<< 3) - w_word[ACC_W-1:0];
          OP_SETEN: begin
            if (32'(g) == s2_addr_q)              acc_d[g] = ACC_W'($signed(s2_data_q[31:16]));
            else if (32'(g) == s2_addr_q + 32'd1) acc_d[g] = ACC_W'($signed(s2_data_q[15:0]));
          end
          OP_NORM8: pool_d[g] = pool_q[g] - w_word[ACC_W-1:0];
          default: ;
        endcase
      end
    end
  end

  // Per-core acc/pool registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < N_CORES; g++) begin
        acc_q[g]  <= '0;
        pool_q[g] <= ACC_MIN;
      end
    end else begin
      for (int g = 0; g < N_CORES; g++) begin
        acc_q[g]  <= acc_d[g];
        pool_q[g] <= pool_d[g];
      end
    end
  end

  // Pool sign bits, zero-padded to whole 32-bit ACTIV windows.
  always_comb begin
    sign_pad = '0;
    for (int g = 0; g < N_CORES; g++) sign_pad[g] = pool_q[g][ACC_W-1];
  end

  assign act_sel = int'(s2_addr_q[1:0]) % N_GROUPS;

`ifdef BNN_IP8_EN
  // Bits [31:8] of core word idx; cores past the array read as zero.
  function automatic logic [23:0] core_hi(input logic [N_CORES*32-1:0] bus, input int idx);
    core_hi = '0;
    if (idx < N_CORES) core_hi = bus[32*(N_CORES-1-idx)+8 +: 24];
  endfunction

  // Sum of three signed byte products, arithmetic shift by 0/1/2/4, low 16 bits.
  function automatic logic [15:0] dot3(input logic [23:0] a, input logic [23:0] b,
                                       input logic [1:0] sft);
    logic signed [7:0]  ai, bi;
    logic signed [15:0] p;
    logic signed [19:0] sum, shifted;
    sum = '0;
    for (int i = 0; i < 3; i++) begin
      ai  = a[8*i +: 8];
      bi  = b[8*i +: 8];
      p   = 16'(ai) * 16'(bi);
      sum = sum + 20'(p);
    end
    case (sft)
      2'd0:    shifted = sum;
      2'd1:    shifted = sum >>> 1;
      2'd2:    shifted = sum >>> 2;
      default: shifted = sum >>> 4;
    endcase
    return shifted[15:0];
  endfunction

  int          ip_j2;
  logic [15:0] ip0, ip1;

  // IP8 result from core words 2j and 2j+1 plus the data operand halves.
  always_comb begin
    ip_j2    = 2 * int'(s2_addr_q[3:0]);
    ip0      = dot3(s2_addr_q[31:8], core_hi(s2_w_q, ip_j2), s2_sft_q);
    ip1      = dot3(s2_addr_q[31:8], core_hi(s2_w_q, ip_j2 + 1), s2_sft_q);
    ip8_word = {ip0 + s2_data_q[31:16], ip1 + s2_data_q[15:0]};
  end
`else
  assign ip8_word = '0;
`endif

  // Result selection for the op reaching the end of the pipe.
  always_comb begin
    result_d = ip8_word;
    if (s2_op_q == OP_ACTIV) result_d = sign_pad[32*act_sel +: 32];
  end

endmodule
